// File: rtl/reg_dw_downsizer.sv
// Register-interface data-width downsizer.
// Splits one wide register transaction into a sequence of narrow beats.
// Reads always issue every beat, low beat first. Writes issue only the beats
// whose strobe slice is non-zero. Beat responses are gathered into a single
// upstream response that is presented for one cycle.

package reg_dw_downsizer_pkg;

    // Default 64-bit upstream request/response shapes.
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic        valid;
    } reg_req64_t;

    typedef struct packed {
        logic [63:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp64_t;

    // Default 32-bit downstream request/response shapes.
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req32_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp32_t;

endpackage

module reg_dw_downsizer
    import reg_dw_downsizer_pkg::*;
#(
    parameter int unsigned AddrWidth    = 32,
    parameter int unsigned InDataWidth  = 64,
    parameter int unsigned OutDataWidth = 32,
    parameter type         req_in_t     = reg_req64_t,
    parameter type         rsp_in_t     = reg_rsp64_t,
    parameter type         req_out_t    = reg_req32_t,
    parameter type         rsp_out_t    = reg_rsp32_t
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  req_in_t  in_req_i,
    output rsp_in_t  in_rsp_o,
    output req_out_t out_req_o,
    input  rsp_out_t out_rsp_i
);

    localparam int unsigned Ratio    = InDataWidth / OutDataWidth;
    localparam int unsigned InBytes  = InDataWidth / 8;
    localparam int unsigned OutBytes = OutDataWidth / 8;
    localparam int unsigned IdxW     = $clog2(Ratio);
    localparam int unsigned OutOffW  = $clog2(OutBytes);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_e;

    state_e                  state_q;
    logic [IdxW-1:0]         idx_q;
    logic [InDataWidth-1:0]  rdata_q;
    logic                    err_q;

    logic                    beat_act;
    logic                    first_found;
    logic [IdxW-1:0]         first_idx;
    logic                    next_found;
    logic [IdxW-1:0]         next_idx;

    logic [AddrWidth-1:0]    base_addr;
    logic [AddrWidth-1:0]    beat_addr;
    logic [OutDataWidth-1:0] beat_wdata;
    logic [OutBytes-1:0]     beat_wstrb;

    // Find the first active beat and the active beat following idx_q.
    always_comb begin
        beat_act    = 1'b0;
        first_found = 1'b0;
        first_idx   = '0;
        next_found  = 1'b0;
        next_idx    = '0;
        for (int unsigned k = 0; k < Ratio; k++) begin
            beat_act = !in_req_i.write || (|in_req_i.wstrb[k*OutBytes +: OutBytes]);
            if (beat_act && !first_found) begin
                first_found = 1'b1;
                first_idx   = IdxW'(k);
            end
            if (beat_act && !next_found && (IdxW'(k) > idx_q)) begin
                next_found = 1'b1;
                next_idx   = IdxW'(k);
            end
        end
    end

    // Select the address, data and strobe of the current beat from the held request.
    always_comb begin
        base_addr  = in_req_i.addr & ~AddrWidth'(InBytes - 1);
        beat_addr  = base_addr + (AddrWidth'(idx_q) << OutOffW);
        beat_wdata = '0;
        beat_wstrb = '0;
        for (int unsigned k = 0; k < Ratio; k++) begin
            if (idx_q == IdxW'(k)) begin
                beat_wdata = in_req_i.wdata[k*OutDataWidth +: OutDataWidth];
                beat_wstrb = in_req_i.wstrb[k*OutBytes +: OutBytes];
            end
        end
    end

    // Sequencer: accept a request, walk the active beats, then pulse the response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_req_i.valid) begin
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                        // A write with no strobes has no active beat at all.
                        if (!first_found) begin
                            state_q <= RESP;
                        end else begin
                            idx_q   <= first_idx;
                            state_q <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (out_rsp_i.ready) begin
                        err_q <= err_q | out_rsp_i.error;
                        if (!in_req_i.write) begin
                            for (int unsigned k = 0; k < Ratio; k++) begin
                                if (idx_q == IdxW'(k)) begin
                                    rdata_q[k*OutDataWidth +: OutDataWidth] <= out_rsp_i.rdata;
                                end
                            end
                        end
                        if (next_found) begin
                            idx_q <= next_idx;
                        end else begin
                            state_q <= RESP;
                        end
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Downstream request: only driven while a beat is being issued.
    always_comb begin
        out_req_o = '0;
        if (state_q == ISSUE) begin
            out_req_o.addr  = beat_addr;
            out_req_o.write = in_req_i.write;
            out_req_o.wdata = beat_wdata;
            out_req_o.wstrb = beat_wstrb;
            out_req_o.valid = 1'b1;
        end
    end

    // Upstream response: gathered data and error, ready for the single RESP cycle.
    always_comb begin
        in_rsp_o       = '0;
        in_rsp_o.rdata = rdata_q;
        in_rsp_o.error = err_q;
        in_rsp_o.ready = (state_q == RESP);
    end

endmodule

// File: tb/tb_reg_dw_downsizer.sv
// Directed testbench for reg_dw_downsizer at 64->32 and 128->32.
module tb_reg_dw_downsizer;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic        valid;
    } req64_t;

    typedef struct packed {
        logic [63:0] rdata;
        logic        error;
        logic        ready;
    } rsp64_t;

    typedef struct packed {
        logic [31:0]  addr;
        logic         write;
        logic [127:0] wdata;
        logic [15:0]  wstrb;
        logic         valid;
    } req128_t;

    typedef struct packed {
        logic [127:0] rdata;
        logic         error;
        logic         ready;
    } rsp128_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } req32_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } rsp32_t;

    logic    clk;
    logic    rst_n;
    req64_t  in64;
    rsp64_t  in64_rsp;
    req32_t  o64;
    rsp32_t  o64_rsp;
    req128_t in128;
    rsp128_t in128_rsp;
    req32_t  o128;
    rsp32_t  o128_rsp;

    int tests_run;
    int tests_failed;

    // Downstream responder configuration, per beat.
    int          rsp_wait  [8];
    logic [31:0] rsp_rdata [8];
    logic        rsp_err   [8];

    // Observations of one transaction.
    logic [31:0]  log_addr  [8];
    logic [31:0]  log_wdata [8];
    logic [3:0]   log_wstrb [8];
    logic         log_write [8];
    int           log_n;
    int           ready_cyc;
    int           valid_cycles;
    logic         unstable;
    logic [127:0] got_rdata;
    logic         got_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    reg_dw_downsizer #(
        .AddrWidth   (32),
        .InDataWidth (64),
        .OutDataWidth(32),
        .req_in_t    (req64_t),
        .rsp_in_t    (rsp64_t),
        .req_out_t   (req32_t),
        .rsp_out_t   (rsp32_t)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .in_req_i (in64),
        .in_rsp_o (in64_rsp),
        .out_req_o(o64),
        .out_rsp_i(o64_rsp)
    );

    reg_dw_downsizer #(
        .AddrWidth   (32),
        .InDataWidth (128),
        .OutDataWidth(32),
        .req_in_t    (req128_t),
        .rsp_in_t    (rsp128_t),
        .req_out_t   (req32_t),
        .rsp_out_t   (rsp32_t)
    ) dut4 (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .in_req_i (in128),
        .in_rsp_o (in128_rsp),
        .out_req_o(o128),
        .out_rsp_i(o128_rsp)
    );

    task automatic set_cfg(input int w0, input int w1, input logic e0, input logic e1,
                           input logic [31:0] r0, input logic [31:0] r1,
                           input logic [31:0] r2, input logic [31:0] r3);
        for (int i = 0; i < 8; i++) begin
            rsp_wait[i]  = 0;
            rsp_rdata[i] = '0;
            rsp_err[i]   = 1'b0;
        end
        rsp_wait[0] = w0;  rsp_wait[1] = w1;
        rsp_err[0]  = e0;  rsp_err[1]  = e1;
        rsp_rdata[0] = r0; rsp_rdata[1] = r1; rsp_rdata[2] = r2; rsp_rdata[3] = r3;
    endtask

    // Drive one request into the 64-bit instance and act as the downstream slave.
    task automatic drive64(input logic [31:0] addr, input logic wr,
                           input logic [63:0] wd, input logic [7:0] ws);
        int   b;
        int   w;
        logic done;
        b = 0; w = 0; done = 1'b0;
        log_n = 0; ready_cyc = -1; valid_cycles = 0; unstable = 1'b0;
        got_rdata = '0; got_err = 1'b0;
        in64 = '0;
        in64.addr = addr; in64.write = wr; in64.wdata = wd; in64.wstrb = ws; in64.valid = 1'b1;
        o64_rsp = '0;
        for (int t = 1; t <= 40 && !done; t++) begin
            @(posedge clk); #1;
            o64_rsp = '0;
            if (in64_rsp.ready) begin
                ready_cyc = t; got_rdata = {64'h0, in64_rsp.rdata}; got_err = in64_rsp.error;
                in64 = '0; done = 1'b1;
            end else if (o64.valid) begin
                valid_cycles++;
                if (b < 8) begin
                    if (w == 0) begin
                        log_addr[b] = o64.addr; log_wdata[b] = o64.wdata;
                        log_wstrb[b] = o64.wstrb; log_write[b] = o64.write;
                    end else if (o64.addr !== log_addr[b] || o64.wdata !== log_wdata[b] ||
                                 o64.wstrb !== log_wstrb[b] || o64.write !== log_write[b]) begin
                        unstable = 1'b1;
                    end
                    if (w >= rsp_wait[b]) begin
                        o64_rsp.ready = 1'b1; o64_rsp.rdata = rsp_rdata[b]; o64_rsp.error = rsp_err[b];
                        b++; log_n = b; w = 0;
                    end else begin
                        w++;
                    end
                end
            end
        end
        in64 = '0; o64_rsp = '0;
        @(posedge clk); #1;
    endtask

    // Same as drive64 for the 128-bit instance.
    task automatic drive128(input logic [31:0] addr, input logic wr,
                            input logic [127:0] wd, input logic [15:0] ws);
        int   b;
        int   w;
        logic done;
        b = 0; w = 0; done = 1'b0;
        log_n = 0; ready_cyc = -1; valid_cycles = 0; unstable = 1'b0;
        got_rdata = '0; got_err = 1'b0;
        in128 = '0;
        in128.addr = addr; in128.write = wr; in128.wdata = wd; in128.wstrb = ws; in128.valid = 1'b1;
        o128_rsp = '0;
        for (int t = 1; t <= 40 && !done; t++) begin
            @(posedge clk); #1;
            o128_rsp = '0;
            if (in128_rsp.ready) begin
                ready_cyc = t; got_rdata = in128_rsp.rdata; got_err = in128_rsp.error;
                in128 = '0; done = 1'b1;
            end else if (o128.valid) begin
                valid_cycles++;
                if (b < 8) begin
                    if (w == 0) begin
                        log_addr[b] = o128.addr; log_wdata[b] = o128.wdata;
                        log_wstrb[b] = o128.wstrb; log_write[b] = o128.write;
                    end else if (o128.addr !== log_addr[b] || o128.wdata !== log_wdata[b] ||
                                 o128.wstrb !== log_wstrb[b] || o128.write !== log_write[b]) begin
                        unstable = 1'b1;
                    end
                    if (w >= rsp_wait[b]) begin
                        o128_rsp.ready = 1'b1; o128_rsp.rdata = rsp_rdata[b]; o128_rsp.error = rsp_err[b];
                        b++; log_n = b; w = 0;
                    end else begin
                        w++;
                    end
                end
            end
        end
        in128 = '0; o128_rsp = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in64 = '0; o64_rsp = '0; in128 = '0; o128_rsp = '0;
        #12;
        tests_run++; if (o64.valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", o64.valid); end
        tests_run++; if (in64_rsp.ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready: got %b expected 0", in64_rsp.ready); end
        tests_run++; if (in64_rsp.rdata !== 64'h0) begin tests_failed++; $display("FAIL reset_rdata: got %h expected 0", in64_rsp.rdata); end
        tests_run++; if (in64_rsp.error !== 1'b0) begin tests_failed++; $display("FAIL reset_error: got %b expected 0", in64_rsp.error); end
        tests_run++; if (o64.addr !== 32'h0) begin tests_failed++; $display("FAIL reset_out_addr: got %h expected 0", o64.addr); end
        tests_run++; if (in128_rsp.rdata !== 128'h0) begin tests_failed++; $display("FAIL reset_rdata128: got %h expected 0", in128_rsp.rdata); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        tests_run++; if (o128.valid !== 1'b0) begin tests_failed++; $display("FAIL post_reset_valid128: got %b expected 0", o128.valid); end
    endtask

    task automatic test_read();
        set_cfg(0, 0, 1'b0, 1'b0, 32'h1111_1111, 32'h2222_2222, 32'h0, 32'h0);
        drive64(32'h100, 1'b0, 64'h0, 8'h00);
        tests_run++; if (log_n !== 2) begin tests_failed++; $display("FAIL read_beats: got %0d expected 2", log_n); end
        tests_run++; if (log_addr[0] !== 32'h100) begin tests_failed++; $display("FAIL read_addr0: got %h expected 100", log_addr[0]); end
        tests_run++; if (log_addr[1] !== 32'h104) begin tests_failed++; $display("FAIL read_addr1: got %h expected 104", log_addr[1]); end
        tests_run++; if (log_write[0] !== 1'b0) begin tests_failed++; $display("FAIL read_write_bit: got %b expected 0", log_write[0]); end
        tests_run++; if (ready_cyc !== 3) begin tests_failed++; $display("FAIL read_ready_cycle: got %0d expected 3", ready_cyc); end
        tests_run++; if (got_rdata[63:0] !== 64'h2222_2222_1111_1111) begin tests_failed++; $display("FAIL read_rdata: got %h expected 2222222211111111", got_rdata[63:0]); end
        tests_run++; if (got_err !== 1'b0) begin tests_failed++; $display("FAIL read_error: got %b expected 0", got_err); end
        tests_run++; if (in64_rsp.ready !== 1'b0) begin tests_failed++; $display("FAIL read_ready_pulse: got %b expected 0", in64_rsp.ready); end
        tests_run++; if (in64_rsp.rdata !== 64'h2222_2222_1111_1111) begin tests_failed++; $display("FAIL read_rdata_hold: got %h expected 2222222211111111", in64_rsp.rdata); end
    endtask

    task automatic test_write_upper();
        set_cfg(0, 0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0, 32'h0);
        drive64(32'h10C, 1'b1, 64'hAABB_CCDD_0000_0000, 8'hF0);
        tests_run++; if (log_n !== 1) begin tests_failed++; $display("FAIL wr_beats: got %0d expected 1", log_n); end
        tests_run++; if (log_addr[0] !== 32'h10C) begin tests_failed++; $display("FAIL wr_addr: got %h expected 10c", log_addr[0]); end
        tests_run++; if (log_wdata[0] !== 32'hAABB_CCDD) begin tests_failed++; $display("FAIL wr_wdata: got %h expected aabbccdd", log_wdata[0]); end
        tests_run++; if (log_wstrb[0] !== 4'hF) begin tests_failed++; $display("FAIL wr_wstrb: got %h expected f", log_wstrb[0]); end
        tests_run++; if (log_write[0] !== 1'b1) begin tests_failed++; $display("FAIL wr_write_bit: got %b expected 1", log_write[0]); end
        tests_run++; if (ready_cyc !== 2) begin tests_failed++; $display("FAIL wr_ready_cycle: got %0d expected 2", ready_cyc); end
        tests_run++; if (got_rdata[63:0] !== 64'h0) begin tests_failed++; $display("FAIL wr_rdata: got %h expected 0", got_rdata[63:0]); end
    endtask

    task automatic test_zero_strobe();
        set_cfg(0, 0, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
        drive64(32'h100, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
        tests_run++; if (valid_cycles !== 0) begin tests_failed++; $display("FAIL zs_out_valid_cycles: got %0d expected 0", valid_cycles); end
        tests_run++; if (ready_cyc !== 1) begin tests_failed++; $display("FAIL zs_ready_cycle: got %0d expected 1", ready_cyc); end
        tests_run++; if (got_err !== 1'b0) begin tests_failed++; $display("FAIL zs_error: got %b expected 0", got_err); end
    endtask

    task automatic test_error_wait();
        set_cfg(0, 3, 1'b1, 1'b0, 32'h3333_3333, 32'h4444_4444, 32'h0, 32'h0);
        drive64(32'h206, 1'b0, 64'h0, 8'h00);
        tests_run++; if (log_n !== 2) begin tests_failed++; $display("FAIL err_beats: got %0d expected 2", log_n); end
        tests_run++; if (log_addr[0] !== 32'h200) begin tests_failed++; $display("FAIL err_addr0: got %h expected 200", log_addr[0]); end
        tests_run++; if (log_addr[1] !== 32'h204) begin tests_failed++; $display("FAIL err_addr1: got %h expected 204", log_addr[1]); end
        tests_run++; if (ready_cyc !== 6) begin tests_failed++; $display("FAIL err_ready_cycle: got %0d expected 6", ready_cyc); end
        tests_run++; if (got_err !== 1'b1) begin tests_failed++; $display("FAIL err_error: got %b expected 1", got_err); end
        tests_run++; if (got_rdata[63:0] !== 64'h4444_4444_3333_3333) begin tests_failed++; $display("FAIL err_rdata: got %h expected 4444444433333333", got_rdata[63:0]); end
        tests_run++; if (unstable !== 1'b0) begin tests_failed++; $display("FAIL err_fields_stable: got %b expected 0", unstable); end
    endtask

    task automatic test_back_to_back();
        set_cfg(1, 0, 1'b0, 1'b0, 32'h9999_9999, 32'h9999_9999, 32'h0, 32'h0);
        drive64(32'h40, 1'b1, 64'h0123_4567_89AB_CDEF, 8'hFF);
        tests_run++; if (log_n !== 2) begin tests_failed++; $display("FAIL b2b_wr_beats: got %0d expected 2", log_n); end
        tests_run++; if (log_addr[1] !== 32'h44) begin tests_failed++; $display("FAIL b2b_wr_addr1: got %h expected 44", log_addr[1]); end
        tests_run++; if (log_wdata[0] !== 32'h89AB_CDEF) begin tests_failed++; $display("FAIL b2b_wr_wdata0: got %h expected 89abcdef", log_wdata[0]); end
        tests_run++; if (log_wdata[1] !== 32'h0123_4567) begin tests_failed++; $display("FAIL b2b_wr_wdata1: got %h expected 01234567", log_wdata[1]); end
        tests_run++; if (ready_cyc !== 4) begin tests_failed++; $display("FAIL b2b_wr_ready_cycle: got %0d expected 4", ready_cyc); end
        tests_run++; if (got_err !== 1'b0) begin tests_failed++; $display("FAIL b2b_wr_error_cleared: got %b expected 0", got_err); end
        tests_run++; if (got_rdata[63:0] !== 64'h0) begin tests_failed++; $display("FAIL b2b_wr_rdata: got %h expected 0", got_rdata[63:0]); end
        set_cfg(0, 0, 1'b0, 1'b0, 32'h0000_0005, 32'h0000_0006, 32'h0, 32'h0);
        drive64(32'h80, 1'b0, 64'h0, 8'h00);
        tests_run++; if (ready_cyc !== 3) begin tests_failed++; $display("FAIL b2b_rd_ready_cycle: got %0d expected 3", ready_cyc); end
        tests_run++; if (got_rdata[63:0] !== 64'h0000_0006_0000_0005) begin tests_failed++; $display("FAIL b2b_rd_rdata: got %h expected 0000000600000005", got_rdata[63:0]); end
    endtask

    task automatic test_ratio4();
        logic [31:0] exp_addr [4];
        exp_addr[0] = 32'h20; exp_addr[1] = 32'h24; exp_addr[2] = 32'h28; exp_addr[3] = 32'h2C;
        set_cfg(0, 0, 1'b0, 1'b0, 32'hDEAD_0000, 32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003);
        drive128(32'h20, 1'b0, 128'h0, 16'h0000);
        tests_run++; if (log_n !== 4) begin tests_failed++; $display("FAIL r4_beats: got %0d expected 4", log_n); end
        for (int i = 0; i < 4; i++) begin
            tests_run++; if (log_addr[i] !== exp_addr[i]) begin tests_failed++; $display("FAIL r4_addr%0d: got %h expected %h", i, log_addr[i], exp_addr[i]); end
        end
        tests_run++; if (ready_cyc !== 5) begin tests_failed++; $display("FAIL r4_ready_cycle: got %0d expected 5", ready_cyc); end
        tests_run++; if (got_rdata !== 128'hDEAD_0003_DEAD_0002_DEAD_0001_DEAD_0000) begin tests_failed++; $display("FAIL r4_rdata: got %h expected dead0003dead0002dead0001dead0000", got_rdata); end
        set_cfg(0, 0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        drive128(32'h30, 1'b1, 128'h4444_4444_3333_3333_2222_2222_1111_1111, 16'hF00F);
        tests_run++; if (log_n !== 2) begin tests_failed++; $display("FAIL r4_sparse_beats: got %0d expected 2", log_n); end
        tests_run++; if (log_addr[0] !== 32'h30) begin tests_failed++; $display("FAIL r4_sparse_addr0: got %h expected 30", log_addr[0]); end
        tests_run++; if (log_addr[1] !== 32'h3C) begin tests_failed++; $display("FAIL r4_sparse_addr1: got %h expected 3c", log_addr[1]); end
        tests_run++; if (log_wdata[1] !== 32'h4444_4444) begin tests_failed++; $display("FAIL r4_sparse_wdata1: got %h expected 44444444", log_wdata[1]); end
        tests_run++; if (ready_cyc !== 3) begin tests_failed++; $display("FAIL r4_sparse_ready_cycle: got %0d expected 3", ready_cyc); end
        tests_run++; if (got_rdata !== 128'h0) begin tests_failed++; $display("FAIL r4_sparse_rdata: got %h expected 0", got_rdata); end
    endtask

    task automatic test_async_reset();
        in128 = '0;
        in128.addr = 32'h50; in128.write = 1'b1; in128.wstrb = 16'hFFFF;
        in128.wdata = 128'h5555_5555_6666_6666_7777_7777_8888_8888; in128.valid = 1'b1;
        o128_rsp = '0;
        @(posedge clk); #1;
        tests_run++; if (o128.valid !== 1'b1) begin tests_failed++; $display("FAIL ar_beat0_valid: got %b expected 1", o128.valid); end
        o128_rsp.ready = 1'b1; o128_rsp.error = 1'b1;
        @(posedge clk); #1;
        o128_rsp = '0;
        tests_run++; if (o128.addr !== 32'h54 || o128.valid !== 1'b1) begin tests_failed++; $display("FAIL ar_beat1: got addr %h valid %b expected addr 54 valid 1", o128.addr, o128.valid); end
        tests_run++; if (in128_rsp.error !== 1'b1) begin tests_failed++; $display("FAIL ar_error_before: got %b expected 1", in128_rsp.error); end
        #3 rst_n = 1'b0;
        #1;
        tests_run++; if (o128.valid !== 1'b0) begin tests_failed++; $display("FAIL ar_valid_drop: got %b expected 0", o128.valid); end
        tests_run++; if (o128.addr !== 32'h0 || o128.wdata !== 32'h0 || o128.wstrb !== 4'h0 || o128.write !== 1'b0) begin tests_failed++; $display("FAIL ar_fields_zero: got addr %h wdata %h wstrb %h write %b expected all 0", o128.addr, o128.wdata, o128.wstrb, o128.write); end
        tests_run++; if (in128_rsp.error !== 1'b0 || in128_rsp.ready !== 1'b0) begin tests_failed++; $display("FAIL ar_rsp_zero: got error %b ready %b expected 0 0", in128_rsp.error, in128_rsp.ready); end
        in128 = '0;
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        set_cfg(0, 0, 1'b0, 1'b0, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'h0000_0004);
        drive128(32'h70, 1'b0, 128'h0, 16'h0000);
        tests_run++; if (log_n !== 4 || log_addr[0] !== 32'h70) begin tests_failed++; $display("FAIL ar_after_beats: got n %0d addr0 %h expected n 4 addr0 70", log_n, log_addr[0]); end
        tests_run++; if (ready_cyc !== 5) begin tests_failed++; $display("FAIL ar_after_ready_cycle: got %0d expected 5", ready_cyc); end
        tests_run++; if (got_rdata !== 128'h0000_0004_0000_0003_0000_0002_0000_0001) begin tests_failed++; $display("FAIL ar_after_rdata: got %h expected 00000004000000030000000200000001", got_rdata); end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_read();
        test_write_upper();
        test_zero_strobe();
        test_error_wait();
        test_back_to_back();
        test_ratio4();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

endmodule
